audio_i2s_link: RTL and testbench

Serial link between the sound mixer and the audio codec. Each frame it latches one 16-bit mono DAC sample and sends it to both channels as I2S. It also deserialises the codec's left ADC channel into a 16-bit parallel word for the tape-input slicer. All codec clocks (BCK, LRCK, ADCLRCK) are derived from clk18 by integer division, and the block is the codec bus master.

---
 rtl/audio_i2s_link_if.sv | 25 ++
 rtl/audio_i2s_link.sv | 110 +++++++++++
 tb/tb_audio_i2s_link.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/audio_i2s_link_if.sv
// Codec-side I2S bus of audio_i2s_link: bit clock, word selects and both serial data lines.
// The link block is the bus master and drives every clock; the codec only returns ADC data.
interface audio_i2s_link_if;
    logic oAUD_BCK;
    logic oAUD_LRCK;
    logic oAUD_DATA;
    logic iAUD_ADCDAT;
    logic oAUD_ADCLRCK;

    modport master (
        output oAUD_BCK,
        output oAUD_LRCK,
        output oAUD_DATA,
        output oAUD_ADCLRCK,
        input  iAUD_ADCDAT
    );

    modport slave (
        input  oAUD_BCK,
        input  oAUD_LRCK,
        input  oAUD_DATA,
        input  oAUD_ADCLRCK,
        output iAUD_ADCDAT
    );
endinterface

// File: rtl/audio_i2s_link.sv
// I2S master: sends one latched mono sample per frame on both DAC channels and
// deserialises the codec's left ADC channel. All bus clocks are divided down from clk18.
module audio_i2s_link #(
    parameter int unsigned BCK_HALF = 6,
    parameter int unsigned WIDTH    = 16
) (
    input  logic             clk18,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] dac_in,
    output logic             frame_strobe,
    output logic [WIDTH-1:0] adc_out,
    output logic             adc_valid,
    audio_i2s_link_if.master aud
);

    localparam int unsigned PreW  = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
    localparam int unsigned HbW   = $clog2(4 * WIDTH);
    localparam int unsigned SlotW = HbW - 1;
    localparam int unsigned IdxW  = $clog2(WIDTH);

    localparam logic [PreW-1:0]  PreLast  = PreW'(BCK_HALF - 1);
    localparam logic [HbW-1:0]   HbLast   = HbW'(4 * WIDTH - 1);
    localparam logic [HbW-1:0]   HbRight  = HbW'(2 * WIDTH);
    localparam logic [SlotW-1:0] SlotLast = SlotW'(WIDTH);

    logic [PreW-1:0]  pre_q, pre_d;
    logic [HbW-1:0]   hb_q, hb_d;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [WIDTH-1:0] adc_q, adc_d;
    logic             valid_q, valid_d;
    logic             data_q, data_d;
    logic             lrck_q, lrck_d;

    logic             hb_step;
    logic             frame_start;
    logic             capture;
    logic [SlotW-1:0] slot_q, slot_d;
    logic [IdxW-1:0]  bit_idx;
    int unsigned      slot_mod;

    always_comb begin
        pre_d       = (pre_q == PreLast) ? '0 : pre_q + 1'b1;
        hb_step     = (pre_q == PreLast);
        hb_d        = hb_q;
        if (hb_step) begin
            hb_d = (hb_q == HbLast) ? '0 : hb_q + 1'b1;
        end
        frame_start = (pre_q == '0) && (hb_q == '0);
        slot_q      = hb_q[HbW-1:1];
        slot_d      = hb_d[HbW-1:1];
        lrck_d      = (hb_d >= HbRight);

        // One-BCK delay: slot s carries bit (-s mod WIDTH), so slot 0 still shows the
        // outgoing word's LSB because W is only reloaded at the end of the frame-start cycle.
        slot_mod = 32'(slot_d) % WIDTH;
        bit_idx  = (slot_mod == 0) ? '0 : IdxW'(WIDTH - slot_mod);
        data_d   = data_q;
        if (hb_step && !hb_d[0]) begin
            data_d = w_q[bit_idx];
        end

        // hb_d odd after a step means hb went even->odd: the BCK rising edge.
        capture = hb_step && hb_d[0];
        shift_d = shift_q;
        adc_d   = adc_q;
        valid_d = 1'b0;
        if (capture && (slot_q != '0) && (slot_q <= SlotLast)) begin
            shift_d = {shift_q[WIDTH-3:0], aud.iAUD_ADCDAT};
            if (slot_q == SlotLast) begin
                adc_d   = {shift_q, aud.iAUD_ADCDAT};
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk18) begin
        if (!reset_n) begin
            pre_q   <= '0;
            hb_q    <= '0;
            w_q     <= '0;
            shift_q <= '0;
            adc_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 1'b0;
            lrck_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            hb_q    <= hb_d;
            shift_q <= shift_d;
            adc_q   <= adc_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            lrck_q  <= lrck_d;
            if (frame_start) begin
                w_q <= dac_in;
            end
        end
    end

    // Counters sit at zero throughout reset; gating keeps the strobe low until the release cycle.
    assign frame_strobe     = reset_n && frame_start;
    assign adc_out          = adc_q;
    assign adc_valid        = valid_q;
    assign aud.oAUD_BCK     = hb_q[0];
    assign aud.oAUD_LRCK    = lrck_q;
    assign aud.oAUD_ADCLRCK = lrck_q;
    assign aud.oAUD_DATA    = data_q;

endmodule

// File: tb/tb_audio_i2s_link.sv
// Directed bench for audio_i2s_link: clocking, DAC serialisation, latch isolation, ADC capture,
// mid-frame reset, and a BCK_HALF=2 instance with DAC data looped back into the ADC input.
module tb_audio_i2s_link;

    logic        clk18 = 1'b0;
    logic        reset_n = 1'b0;
    logic        reset2_n = 1'b0;
    logic [15:0] dac_in = 16'h0000;
    logic [15:0] dac2 = 16'h0000;
    logic [15:0] left1 = 16'h0000;
    logic [15:0] right1 = 16'h0000;
    logic        fs, fs2, av, av2;
    logic [15:0] adc_out, adc2;
    int          fc1 = 0;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          e_rst, e_fs, e_bck, e_lr, e_alr, e_av, e_adc, e_dchg;
    logic        prev_dat;
    logic        slot0_first;
    logic [15:0] left_dec [8];
    logic [15:0] right_dec [8];

    always #5 clk18 = ~clk18;

    audio_i2s_link_if aud ();
    audio_i2s_link_if aud2 ();

    audio_i2s_link u_dut (
        .clk18        (clk18),
        .reset_n      (reset_n),
        .dac_in       (dac_in),
        .frame_strobe (fs),
        .adc_out      (adc_out),
        .adc_valid    (av),
        .aud          (aud)
    );

    audio_i2s_link #(
        .BCK_HALF (2),
        .WIDTH    (16)
    ) u_dut2 (
        .clk18        (clk18),
        .reset_n      (reset2_n),
        .dac_in       (dac2),
        .frame_strobe (fs2),
        .adc_out      (adc2),
        .adc_valid    (av2),
        .aud          (aud2)
    );

    // Codec model: I2S left/right words, new bit at every slot start (BCK falling edge).
    function automatic logic codec_bit(input int fc, input logic [15:0] l, input logic [15:0] r);
        int s;
        s = fc / 12;
        if (s >= 1 && s <= 16) return l[16 - s];
        if (s >= 17) return r[32 - s];
        return r[0];
    endfunction

    always @(posedge clk18) begin
        if (!reset_n) fc1 <= 0;
        else if (fc1 == 383) fc1 <= 0;
        else fc1 <= fc1 + 1;
    end

    always_comb aud.iAUD_ADCDAT = codec_bit(fc1, left1, right1);
    always_comb aud2.iAUD_ADCDAT = aud2.oAUD_DATA;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        e_fs = 0; e_bck = 0; e_lr = 0; e_alr = 0; e_av = 0; e_adc = 0; e_dchg = 0;
        slot0_first = 1'bx;
    endtask

    // One observation of cycle c (c = 0 is the frame-start cycle) against the I2S timing.
    task automatic sample(input int c, input int half, input logic fs_v, input logic bck_v,
                          input logic lr_v, input logic alr_v, input logic dat_v,
                          input logic av_v, input logic [15:0] adc_v,
                          input logic [15:0] exp_adc);
        int fr, ph, f, s;
        fr = 64 * half;
        ph = c % fr;
        f  = c / fr;
        s  = ph / (2 * half);
        if (fs_v !== (ph == 0)) e_fs++;
        if (bck_v !== 1'((ph / half) % 2)) e_bck++;
        if (lr_v !== (ph >= 32 * half)) e_lr++;
        if (alr_v !== (ph >= 32 * half)) e_alr++;
        if (av_v !== (ph == 33 * half)) e_av++;
        if (adc_v !== exp_adc) e_adc++;
        if (c > 0 && (ph % (2 * half)) != 0 && dat_v !== prev_dat) e_dchg++;
        prev_dat = dat_v;
        if (ph % (2 * half) == half) begin
            if (s >= 1 && s <= 16) left_dec[f] = {left_dec[f][14:0], dat_v};
            else if (s >= 17) right_dec[f] = {right_dec[f][14:0], dat_v};
            else if (f > 0) right_dec[f-1] = {right_dec[f-1][14:0], dat_v};
            else slot0_first = dat_v;
        end
    endtask

    initial begin
        dac_in = 16'hA5C3;
        dac2   = 16'h1234;
        left1  = 16'h8001;
        right1 = 16'h7FFE;

        e_rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk18);
            #1;
            if ({fs, aud.oAUD_BCK, aud.oAUD_LRCK, aud.oAUD_ADCLRCK, aud.oAUD_DATA, av,
                 adc_out} !== '0) e_rst++;
        end
        chk("reset_outputs_zero", e_rst, 0);

        @(negedge clk18);
        reset_n = 1'b1;
        clr();
        for (int c = 0; c < 1548; c++) begin
            if (c > 0) @(negedge clk18);
            if (c == 700) dac_in = 16'h0000;
            if (c == 767) left1 = 16'h4C3A;
            if (c == 868) dac_in = 16'hFFFF;
            #1;
            sample(c, 6, fs, aud.oAUD_BCK, aud.oAUD_LRCK, aud.oAUD_ADCLRCK, aud.oAUD_DATA,
                   av, adc_out, (c < 198) ? 16'h0000 : (c < 966) ? 16'h8001 : 16'h4C3A);
        end
        chk("frame_strobe_every_384", e_fs, 0);
        chk("bck_period_12_duty_50", e_bck, 0);
        chk("lrck_period_384", e_lr, 0);
        chk("adclrck_equals_lrck", e_alr, 0);
        chk("adc_valid_cycle_198", e_av, 0);
        chk("adc_out_left_only", e_adc, 0);
        chk("dac_data_changes_on_fall", e_dchg, 0);
        chk("slot0_after_reset", slot0_first, 0);
        chk("dac_left_f0_a5c3", left_dec[0], 16'hA5C3);
        chk("dac_right_f0_a5c3", right_dec[0], 16'hA5C3);
        chk("dac_left_f1_a5c3", left_dec[1], 16'hA5C3);
        chk("dac_right_f1_isolated", right_dec[1], 16'hA5C3);
        chk("dac_left_f2_0000", left_dec[2], 16'h0000);
        chk("dac_right_f2_0000", right_dec[2], 16'h0000);
        chk("dac_left_f3_ffff", left_dec[3], 16'hFFFF);
        chk("dac_right_f3_ffff", right_dec[3], 16'hFFFF);

        clr();
        for (int c = 1548; c <= 1636; c++) begin
            @(negedge clk18);
            #1;
            sample(c, 6, fs, aud.oAUD_BCK, aud.oAUD_LRCK, aud.oAUD_ADCLRCK, aud.oAUD_DATA,
                   av, adc_out, 16'h4C3A);
        end
        chk("pre_reset_run", e_fs + e_bck + e_lr + e_alr + e_av + e_adc + e_dchg, 0);

        // Frame cycle 100: reset held for three edges.
        reset_n = 1'b0;
        e_rst = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk18);
            #1;
            if ({fs, aud.oAUD_BCK, aud.oAUD_LRCK, aud.oAUD_ADCLRCK, aud.oAUD_DATA, av,
                 adc_out} !== '0) e_rst++;
        end
        chk("mid_reset_outputs_zero", e_rst, 0);

        @(negedge clk18);
        dac_in  = 16'h3C5A;
        left1   = 16'h8001;
        reset_n = 1'b1;
        clr();
        for (int c = 0; c < 780; c++) begin
            if (c > 0) @(negedge clk18);
            #1;
            sample(c, 6, fs, aud.oAUD_BCK, aud.oAUD_LRCK, aud.oAUD_ADCLRCK, aud.oAUD_DATA,
                   av, adc_out, (c < 198) ? 16'h0000 : 16'h8001);
        end
        chk("post_reset_timing", e_fs + e_bck + e_lr + e_alr + e_dchg, 0);
        chk("post_reset_adc_valid", e_av, 0);
        chk("post_reset_no_partial_word", e_adc, 0);
        chk("post_reset_slot0_cleared", slot0_first, 0);
        chk("post_reset_left_f0", left_dec[0], 16'h3C5A);
        chk("post_reset_right_f0", right_dec[0], 16'h3C5A);
        chk("post_reset_left_f1", left_dec[1], 16'h3C5A);

        @(negedge clk18);
        reset2_n = 1'b1;
        clr();
        for (int c = 0; c < 260; c++) begin
            if (c > 0) @(negedge clk18);
            #1;
            sample(c, 2, fs2, aud2.oAUD_BCK, aud2.oAUD_LRCK, aud2.oAUD_ADCLRCK,
                   aud2.oAUD_DATA, av2, adc2, (c < 66) ? 16'h0000 : 16'h1234);
        end
        chk("half2_frame_strobe_128", e_fs, 0);
        chk("half2_bck_period_4", e_bck, 0);
        chk("half2_lrck", e_lr + e_alr, 0);
        chk("half2_adc_valid_cycle_66", e_av, 0);
        chk("half2_loopback_adc", e_adc, 0);
        chk("half2_data_changes_on_fall", e_dchg, 0);
        chk("half2_left_f0", left_dec[0], 16'h1234);
        chk("half2_right_f0", right_dec[0], 16'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
